quad_step_decoder: RTL and testbench



---
 rtl/quad_step_decoder.sv | 169 ++++++++++++++++
 tb/tb_quad_step_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature phase reader: synchronises and glitch-filters an A/B pair, then
// decodes the Gray sequence into signed position, direction, step interval and stall status.
module quad_step_decoder #(
    parameter int FILTER_LEN   = 4,
    parameter int POS_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24,
    parameter int STALL_CYCLES = 2700000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        phase_a,
    input  logic                        phase_b,
    input  logic                        clear,
    input  logic                        err_clear,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        direction,
    output logic                        step_valid,
    output logic [PERIOD_WIDTH-1:0]     step_period,
    output logic                        stalled,
    output logic                        illegal_err
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0]        FILT_MAX  = CNT_W'(FILTER_LEN);
    localparam logic [PERIOD_WIDTH-1:0] STALL_MAX = PERIOD_WIDTH'(STALL_CYCLES);

    typedef enum logic {INIT, TRACK} dec_state_t;

    logic [1:0]       sync1, sync2;
    logic [1:0]       cand, cand_next;
    logic [CNT_W-1:0] filt_cnt, cnt_next;
    logic [1:0]       acc_pair;
    logic             acc_seen, acc_valid, accept;

    dec_state_t       state, state_next;
    logic [1:0]       phase_reg;
    logic [1:0]       delta;
    logic             load, step_fwd, step_rev, step, bad;

    logic [PERIOD_WIDTH-1:0] ivl_cnt;
    logic                    ivl_known;

    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b10:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {phase_a, phase_b};
            sync2 <= sync1;
        end
    end

    // A pair is accepted only on the edge its stable run first reaches FILTER_LEN,
    // and only if it differs from the last accepted pair (any pair counts once after reset).
    always_comb begin
        cand_next = cand;
        cnt_next  = filt_cnt;
        if (sync2 != cand) begin
            cand_next = sync2;
            cnt_next  = CNT_W'(1);
        end else if (filt_cnt != FILT_MAX) begin
            cnt_next = filt_cnt + 1'b1;
        end
        accept = (cnt_next == FILT_MAX)
               && !((filt_cnt == FILT_MAX) && (sync2 == cand))
               && (!acc_seen || (cand_next != acc_pair));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand      <= 2'b00;
            filt_cnt  <= '0;
            acc_pair  <= 2'b00;
            acc_seen  <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            cand      <= cand_next;
            filt_cnt  <= cnt_next;
            acc_valid <= accept;
            if (accept) begin
                acc_pair <= cand_next;
                acc_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step_fwd   = 1'b0;
        step_rev   = 1'b0;
        bad        = 1'b0;
        delta      = gray_idx(acc_pair) - gray_idx(phase_reg);
        case (state)
            INIT: begin
                if (acc_valid) begin
                    load       = 1'b1;
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (acc_valid) begin
                    load = 1'b1;
                    case (delta)
                        2'd1:    step_fwd = 1'b1;
                        2'd3:    step_rev = 1'b1;
                        2'd2:    bad      = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_next = INIT;
        endcase
        step = step_fwd | step_rev;
    end

    // Clear wins over a coincident step; a new illegal transition wins over err_clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg   <= 2'b00;
            position    <= '0;
            direction   <= 1'b1;
            step_valid  <= 1'b0;
            illegal_err <= 1'b0;
        end else begin
            if (load) phase_reg <= acc_pair;
            step_valid <= step;
            if (step) direction <= step_fwd;
            if (clear)         position <= '0;
            else if (step_fwd) position <= position + 1'b1;
            else if (step_rev) position <= position - 1'b1;
            if (bad)            illegal_err <= 1'b1;
            else if (err_clear) illegal_err <= 1'b0;
        end
    end

    // Interval reads all-ones when no earlier step is known or the counter saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivl_cnt     <= '0;
            ivl_known   <= 1'b0;
            step_period <= '1;
            stalled     <= 1'b1;
        end else if (step) begin
            step_period <= (!ivl_known || (ivl_cnt == STALL_MAX)) ? '1 : ivl_cnt + 1'b1;
            ivl_cnt     <= '0;
            ivl_known   <= 1'b1;
            stalled     <= 1'b0;
        end else if (ivl_cnt != STALL_MAX) begin
            ivl_cnt <= ivl_cnt + 1'b1;
            if ((ivl_cnt + 1'b1) == STALL_MAX) stalled <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: directed scenarios plus a random
// phase walk, compared each cycle against an edge-indexed behavioural model.
module tb_quad_step_decoder;

    localparam int FL    = 4;
    localparam int STALL = 100;

    logic       clk = 1'b0;
    logic       rst, phase_a, phase_b, clear, err_clear;
    logic [3:0] position;
    logic       direction, step_valid, stalled, illegal_err;
    logic [7:0] step_period;

    int checks = 0;
    int errors = 0;

    quad_step_decoder #(
        .FILTER_LEN(FL), .POS_WIDTH(4), .PERIOD_WIDTH(8), .STALL_CYCLES(STALL)
    ) dut (
        .clk(clk), .rst(rst), .phase_a(phase_a), .phase_b(phase_b),
        .clear(clear), .err_clear(err_clear), .position(position),
        .direction(direction), .step_valid(step_valid), .step_period(step_period),
        .stalled(stalled), .illegal_err(illegal_err)
    );

    always #5 clk = ~clk;

    logic [1:0] in_q[$];
    logic [1:0] seen_q[$];
    int         t, last_step;
    bit         have_acc, pend, have_st, have_last;
    logic [1:0] acc_v, pend_v, st_v;
    logic [3:0] m_pos;
    logic [7:0] m_per;
    bit         m_dir, m_step, m_stall, m_ill;

    function automatic int idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] pair_of(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic modelReset();
        t = 0;
        in_q.delete();
        seen_q.delete();
        have_acc = 0; pend = 0; have_st = 0; have_last = 0; last_step = 0;
        m_pos = 4'd0; m_dir = 1; m_step = 0; m_stall = 1; m_ill = 0; m_per = 8'hFF;
    endtask

    // Edge t: the filter sees the input sampled at edge t-2; a value stable for
    // exactly FL observations is accepted, and the decoder acts one edge later.
    task automatic modelEdge(input logic [1:0] p, input bit clr, input bit eclr);
        logic [1:0] s;
        int n, d;
        bit run_ok, ill_now;
        in_q.push_back(p);
        s = (t < 2) ? 2'b00 : in_q[t-2];
        seen_q.push_back(s);
        m_step = 0;
        ill_now = 0;
        if (pend) begin
            if (!have_st) begin
                have_st = 1;
            end else begin
                d = (idx_of(pend_v) - idx_of(st_v) + 4) % 4;
                if (d == 1)      begin m_step = 1; m_dir = 1; m_pos = m_pos + 4'd1; end
                else if (d == 3) begin m_step = 1; m_dir = 0; m_pos = m_pos - 4'd1; end
                else if (d == 2) ill_now = 1;
            end
            st_v = pend_v;
        end
        if (clr) m_pos = 4'd0;
        if (ill_now)   m_ill = 1;
        else if (eclr) m_ill = 0;
        if (m_step) begin
            m_per = (have_last && (t - last_step) <= STALL) ? 8'(t - last_step) : 8'hFF;
            last_step = t;
            have_last = 1;
            m_stall = 0;
        end else begin
            m_stall = !have_last || ((t - last_step) >= STALL);
        end
        n = seen_q.size();
        pend = 0;
        if (n >= FL) begin
            run_ok = 1;
            for (int i = n - FL; i < n; i++) if (seen_q[i] != s) run_ok = 0;
            if (n > FL && seen_q[n-1-FL] == s) run_ok = 0;
            if (run_ok && (!have_acc || s != acc_v)) begin
                have_acc = 1; acc_v = s; pend = 1; pend_v = s;
            end
        end
        t++;
    endtask

    task automatic applyStimulus(input logic [1:0] p, input bit clr, input bit eclr);
        phase_a = p[1];
        phase_b = p[0];
        clear = clr;
        err_clear = eclr;
        @(posedge clk);
        #1;
        modelEdge(p, clr, eclr);
        checkOutput("step_valid", step_valid, m_step);
        checkOutput("position", position, m_pos);
        checkOutput("direction", direction, m_dir);
        checkOutput("step_period", step_period, m_per);
        checkOutput("stalled", stalled, m_stall);
        checkOutput("illegal_err", illegal_err, m_ill);
    endtask

    task automatic holdPair(input logic [1:0] p, input int n);
        repeat (n) applyStimulus(p, 0, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_position"}, position, 0);
        checkOutput({tag, "_direction"}, direction, 1);
        checkOutput({tag, "_step_valid"}, step_valid, 0);
        checkOutput({tag, "_step_period"}, step_period, 8'hFF);
        checkOutput({tag, "_stalled"}, stalled, 1);
        checkOutput({tag, "_illegal_err"}, illegal_err, 0);
    endtask

    task automatic randomWalk(input int segs, inout int gi);
        int r, len;
        for (int seg = 0; seg < segs; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      gi = (gi + 1) % 4;
            else if (r < 80) gi = (gi + 3) % 4;
            else if (r < 88) gi = (gi + 2) % 4;
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(95, 130) : $urandom_range(1, 10);
            repeat (len) applyStimulus(pair_of(gi), $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        int gi;
        rst = 1'b1; phase_a = 1'b0; phase_b = 1'b0; clear = 1'b0; err_clear = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        holdPair(2'b00, 10);
        holdPair(2'b10, 50); holdPair(2'b11, 50); holdPair(2'b01, 50);
        holdPair(2'b00, 50); holdPair(2'b10, 50);
        checkOutput("fwd_position", position, 5);
        checkOutput("fwd_direction", direction, 1);
        checkOutput("fwd_period", step_period, 50);

        holdPair(2'b00, 50); holdPair(2'b01, 50); holdPair(2'b11, 50);
        checkOutput("rev_position", position, 2);
        checkOutput("rev_direction", direction, 0);
        checkOutput("rev_period", step_period, 50);
        checkOutput("rev_stalled", stalled, 0);

        holdPair(2'b10, 50); holdPair(2'b00, 50);
        holdPair(2'b10, 3);  holdPair(2'b00, 20);
        checkOutput("glitch_position", position, 0);
        holdPair(2'b10, 30);
        checkOutput("filtered_step_position", position, 1);
        holdPair(2'b00, 30);

        holdPair(2'b11, 30);
        checkOutput("illegal_set", illegal_err, 1);
        checkOutput("illegal_position", position, 0);
        applyStimulus(2'b11, 0, 1);
        checkOutput("illegal_cleared", illegal_err, 0);
        holdPair(2'b11, 5);
        repeat (6) applyStimulus(2'b00, 0, 0);
        applyStimulus(2'b00, 0, 1);
        checkOutput("illegal_set_wins", illegal_err, 1);
        holdPair(2'b00, 20);

        for (int i = 1; i <= 7; i++) holdPair(pair_of(i), 20);
        checkOutput("wrap_pre_position", position, 7);
        holdPair(2'b00, 20);
        checkOutput("wrap_pos_to_neg", position, 4'h8);
        holdPair(2'b01, 20);
        checkOutput("wrap_neg_to_pos", position, 7);

        repeat (6) applyStimulus(2'b00, 0, 0);
        applyStimulus(2'b00, 1, 0);
        checkOutput("clear_step_valid", step_valid, 1);
        checkOutput("clear_step_position", position, 0);
        holdPair(2'b00, 99);
        checkOutput("stall_before", stalled, 0);
        holdPair(2'b00, 1);
        checkOutput("stall_at_limit", stalled, 1);
        holdPair(2'b00, 50);
        repeat (6) applyStimulus(2'b10, 0, 0);
        applyStimulus(2'b10, 0, 0);
        checkOutput("post_stall_step", step_valid, 1);
        checkOutput("post_stall_stalled", stalled, 0);
        checkOutput("post_stall_period", step_period, 8'hFF);

        gi = 1;
        randomWalk(100, gi);

        #2 rst = 1'b1;
        #1 checkResetValues("async_reset");
        #2 rst = 1'b0;
        modelReset();
        randomWalk(50, gi);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
